// File: rtl/adder_pipe_tagged.sv
// Tagged, valid-qualified pipeline wrapper around the FloPoCo double adder core.
// Carries {valid, last, row} beside the core; adds flush, in-flight count and a sticky error flag.

module FPAdder_11_52_uid2 #(
    parameter int LATENCY = 11
) (
    input  logic        clk,
    input  logic [65:0] X,
    input  logic [65:0] Y,
    output logic [65:0] R
);
    // FloPoCo format: [65:64] exc (00 zero, 01 normal, 10 inf, 11 NaN), [63] sign, [62:52] exp, [51:0] frac
    function automatic logic [65:0] fp_add(input logic [65:0] x, input logic [65:0] y);
        logic [65:0]        a;
        logic [65:0]        b;
        logic [10:0]        d;
        logic [55:0]        ma;
        logic [55:0]        mb;
        logic [55:0]        mb_sh;
        logic [56:0]        sum;
        logic [55:0]        norm;
        logic [53:0]        rnd;
        logic signed [13:0] e;
        logic               sticky;
        int                 lz;
        if (x[65:64] == 2'b11 || y[65:64] == 2'b11) return {2'b11, 64'h0};
        if (x[65:64] == 2'b10 && y[65:64] == 2'b10)
            return (x[63] == y[63]) ? {2'b10, x[63], 63'h0} : {2'b11, 64'h0};
        if (x[65:64] == 2'b10) return {2'b10, x[63], 63'h0};
        if (y[65:64] == 2'b10) return {2'b10, y[63], 63'h0};
        if (x[65:64] == 2'b00 && y[65:64] == 2'b00) return {2'b00, x[63] & y[63], 63'h0};
        if (x[65:64] == 2'b00) return y;
        if (y[65:64] == 2'b00) return x;
        if (x[62:0] >= y[62:0]) begin
            a = x;
            b = y;
        end else begin
            a = y;
            b = x;
        end
        d  = a[62:52] - b[62:52];
        ma = {1'b1, a[51:0], 3'b000};
        mb = {1'b1, b[51:0], 3'b000};
        // three guard bits plus a sticky folded into bit 0 keep round-to-nearest-even exact
        if (d > 11'd55) begin
            mb_sh = 56'h1;
        end else begin
            mb_sh     = mb >> d;
            sticky    = ((mb_sh << d) != mb);
            mb_sh[0]  = mb_sh[0] | sticky;
        end
        if (a[63] == b[63]) sum = {1'b0, ma} + {1'b0, mb_sh};
        else                sum = {1'b0, ma} - {1'b0, mb_sh};
        if (sum == 57'h0) return 66'h0;
        e = {3'b000, a[62:52]};
        if (sum[56]) begin
            norm    = sum[56:1];
            norm[0] = sum[1] | sum[0];
            e       = e + 14'sd1;
        end else begin
            lz = 0;
            for (int i = 0; i < 56; i++) if (sum[i]) lz = 55 - i;
            norm = sum[55:0] << lz;
            e    = e - 14'(lz);
        end
        rnd = {1'b0, norm[55:3]} + {53'h0, norm[2] & (norm[1] | norm[0] | norm[3])};
        if (rnd[53]) begin
            rnd = rnd >> 1;
            e   = e + 14'sd1;
        end
        if (e >= 14'sd2047) return {2'b10, a[63], 63'h0};
        if (e <= 14'sd0)    return {2'b00, a[63], 63'h0};
        return {2'b01, a[63], e[10:0], rnd[51:0]};
    endfunction

    logic [65:0] stage [LATENCY];

    always_ff @(posedge clk) begin
        stage[0] <= fp_add(X, Y);
        for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end

    assign R = stage[LATENCY-1];
endmodule

module adder_pipe_tagged #(
    parameter int ROW_WIDTH   = 10,
    parameter int ADD_LATENCY = 11,
    parameter int OUT_REG     = 0,
    parameter int CNT_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push_in,
    input  logic                 single_in,
    input  logic                 last_in,
    input  logic [ROW_WIDTH-1:0] row_in,
    input  logic [65:0]          v0_in,
    input  logic [65:0]          v1_in,
    output logic                 push_out,
    output logic                 last_out,
    output logic [ROW_WIDTH-1:0] row_out,
    output logic [65:0]          v_out,
    output logic [CNT_WIDTH-1:0] inflight,
    output logic                 idle,
    output logic                 err_sticky,
    input  logic                 err_clr
);
    logic                 accepted;
    logic [65:0]          core_y;
    logic [65:0]          core_r;
    logic                 valid_q [ADD_LATENCY];
    logic                 last_q  [ADD_LATENCY];
    logic [ROW_WIDTH-1:0] row_q   [ADD_LATENCY];

    assign accepted = push_in & rst & ~flush;
    assign core_y   = single_in ? 66'h0 : v1_in;

    FPAdder_11_52_uid2 #(.LATENCY(ADD_LATENCY)) u_core (
        .clk (clk),
        .X   (v0_in),
        .Y   (core_y),
        .R   (core_r)
    );

    // core data drains freely; only valid_q decides what is a result
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ADD_LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                last_q[i]  <= 1'b0;
                row_q[i]   <= '0;
            end
        end else begin
            valid_q[0] <= accepted;
            last_q[0]  <= last_in;
            row_q[0]   <= row_in;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1] & ~flush;
                last_q[i]  <= last_q[i-1];
                row_q[i]   <= row_q[i-1];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk) begin
                if (!rst) begin
                    push_out <= 1'b0;
                    last_out <= 1'b0;
                    row_out  <= '0;
                    v_out    <= 66'h0;
                end else begin
                    push_out <= valid_q[ADD_LATENCY-1] & ~flush;
                    last_out <= last_q[ADD_LATENCY-1];
                    row_out  <= row_q[ADD_LATENCY-1];
                    v_out    <= core_r;
                end
            end
        end else begin : g_noreg
            assign push_out = valid_q[ADD_LATENCY-1];
            assign last_out = last_q[ADD_LATENCY-1];
            assign row_out  = row_q[ADD_LATENCY-1];
            assign v_out    = core_r;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            inflight <= '0;
        end else if (accepted && !push_out) begin
            inflight <= inflight + CNT_WIDTH'(1);
        end else if (!accepted && push_out) begin
            inflight <= inflight - CNT_WIDTH'(1);
        end
    end

    assign idle = (inflight == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_sticky <= 1'b0;
        end else if (push_out && v_out[65]) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
endmodule
